// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream bundle for one side of a pipeline stage.
// The master drives Valid/Data and the slave drives Ready.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 64
);
    logic              Valid;
    logic [DATA_W-1:0] Data;
    logic              Ready;

    modport master (
        output Valid,
        output Data,
        input  Ready
    );

    modport slave (
        input  Valid,
        input  Data,
        output Ready
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with flush, bubble output and
// a saturating stall counter.
module pipe_stage_skid #(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Flush,
    pipe_stage_skid_if.slave  In,
    pipe_stage_skid_if.master Out,
    output logic [1:0]       Occupancy,
    output logic [CNT_W-1:0] Stall_Cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic in_rdy;
    logic out_vld;
    logic in_hs;
    logic out_hs;

    // Ready comes from state alone so Out.Ready never reaches In.Ready.
    assign in_rdy  = Rst_n & (state_q != FULL);
    assign out_vld = (state_q == HALF) | (state_q == FULL);
    assign in_hs   = In.Valid & in_rdy;
    assign out_hs  = out_vld & Out.Ready;

    assign In.Ready  = in_rdy;
    assign Out.Valid = out_vld;
    assign Out.Data  = out_vld ? main_q : NOP_VAL;
    assign Occupancy = state_q;
    assign Stall_Cnt = cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= EMPTY;
            main_q  <= NOP_VAL;
            skid_q  <= NOP_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
            state_d = EMPTY;
            main_d  = NOP_VAL;
            skid_d  = NOP_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        state_d = HALF;
                        main_d  = In.Data;
                    end
                end
                HALF: begin
                    unique case (1'b1)
                        in_hs & out_hs: begin
                            main_d = In.Data;
                        end
                        in_hs & ~out_hs: begin
                            state_d = FULL;
                            skid_d  = In.Data;
                        end
                        ~in_hs & out_hs: begin
                            state_d = EMPTY;
                            main_d  = NOP_VAL;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_hs) begin
                        state_d = HALF;
                        main_d  = skid_q;
                        skid_d  = NOP_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VAL;
                    skid_d  = NOP_VAL;
                end
            endcase
        end
    end

    // Counter survives Flush and sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (out_vld && !Out.Ready && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: queue reference model of the skid stage,
// directed scenarios followed by randomized traffic.
module tb_pipe_stage_skid;

    localparam int          DW  = 16;
    localparam int          CW  = 4;
    localparam logic [15:0] NOP = 16'hBEEF;
    localparam int          SAT = 15;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [1:0]    occ;
    logic [CW-1:0] stall;

    pipe_stage_skid_if #(.DATA_W(DW)) in_if ();
    pipe_stage_skid_if #(.DATA_W(DW)) out_if ();

    pipe_stage_skid #(
        .DATA_W (DW),
        .NOP_VAL(NOP),
        .CNT_W  (CW)
    ) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .Flush    (flush),
        .In       (in_if),
        .Out      (out_if),
        .Occupancy(occ),
        .Stall_Cnt(stall)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string n,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
        end
    endfunction

    // Reference model: ordered list of held entries plus a stall tally.
    logic [15:0] q[$];
    int          stall_m;
    int          n_m;
    bit          ov_m, ih_m, oh_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            stall_m = 0;
        end else begin
            n_m  = q.size();
            ov_m = n_m > 0;
            ih_m = in_if.Valid && n_m < 2;
            oh_m = ov_m && out_if.Ready;
            if (ov_m && !out_if.Ready && stall_m < SAT) stall_m++;
            if (oh_m) void'(q.pop_front());
            if (flush) q.delete();
            else if (ih_m) q.push_back(in_if.Data);
        end
    end

    // Monitor: after inputs settle each cycle, compare against the model.
    always @(negedge clk) begin
        #1;
        chk("occupancy", 64'(occ), 64'(q.size()));
        chk("in_ready", 64'(in_if.Ready), 64'(rst_n && q.size() < 2));
        chk("out_valid", 64'(out_if.Valid), 64'(q.size() > 0));
        chk("out_data", 64'(out_if.Data),
            64'(q.size() > 0 ? q[0] : NOP));
        chk("stall_cnt", 64'(stall), 64'(stall_m));
    end

    task automatic drive(input logic v, input logic [15:0] d,
                         input logic r, input logic f);
        @(negedge clk);
        in_if.Valid  = v;
        in_if.Data   = d;
        out_if.Ready = r;
        flush        = f;
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_if.Valid  = 1'b0;
        in_if.Data   = '0;
        out_if.Ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_in_ready", 64'(in_if.Ready), 64'd0);
        chk("rst_out_data", 64'(out_if.Data), 64'(NOP));
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Backpressure fills both registers
        drive(1'b1, 16'h000A, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("bp_occ", 64'(occ), 64'd2);
        chk("bp_in_ready", 64'(in_if.Ready), 64'd0);
        chk("bp_head", 64'(out_if.Data), 64'h000A);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        #2;
        chk("bp_second", 64'(out_if.Data), 64'h000B);
        drive(1'b0, '0, 1'b1, 1'b0);
        #2;
        chk("bp_drained", 64'(out_if.Data), 64'(NOP));

        // Flush while full, competing input discarded
        drive(1'b1, 16'h000D, 1'b0, 1'b0);
        drive(1'b1, 16'h000E, 1'b0, 1'b0);
        drive(1'b1, 16'h000C, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        #2;
        chk("flush_occ", 64'(occ), 64'd0);
        chk("flush_data", 64'(out_if.Data), 64'(NOP));
        drive(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges while full
        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_occ", 64'(occ), 64'd0);
        chk("arst_valid", 64'(out_if.Valid), 64'd0);
        chk("arst_data", 64'(out_if.Data), 64'(NOP));
        chk("arst_in_ready", 64'(in_if.Ready), 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_if.Valid  = 1'b1;
        in_if.Data   = 16'h0005;
        out_if.Ready = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        #2;
        chk("arst_first", 64'(out_if.Data), 64'h0005);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Stall counter saturation
        drive(1'b1, 16'h0077, 1'b0, 1'b0);
        repeat (20) drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("sat_cnt", 64'(stall), 64'(SAT));
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("sat_hold", 64'(stall), 64'(SAT));
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  16'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
